// File: rtl/pipeline_pkg.sv
// Shared types and constants for the pipeline's SRAM port arbiter.
package pipeline_pkg;

    // Arbiter FSM states.
    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccess = 2'd1,
        StDone   = 2'd2
    } state_e;

    // Port identifiers, also the encoding of the last_grant register.
    localparam logic PORT_IF  = 1'b0;
    localparam logic PORT_MEM = 1'b1;

    // Byte-address bits dropped to form an SRAM word address.
    localparam int unsigned WORD_OFFSET = 2;

    // Width of a down-counter that must hold WAIT_CYCLES-1 (at least 1 bit).
    function automatic int unsigned cnt_width(input int unsigned wait_cycles);
        return (wait_cycles > 1) ? $clog2(wait_cycles) : 1;
    endfunction

endpackage

// File: rtl/sram_wait_counter.sv
// Loadable down-counter that times the SRAM access; flags zero on the final cycle.
module sram_wait_counter #(
    parameter int unsigned WIDTH = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             dec,
    output logic             zero
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] count_q;

    // Load takes priority; decrement saturates at zero.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_value;
        end else if (dec && (count_q != '0)) begin
            count_q <= count_q - ONE;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one fixed-latency, single-ported SRAM between the fetch and memory stages.
// Round-robin on ties, one access per WAIT_CYCLES+2 cycles, one-cycle ready pulses.
module sram_port_arbiter
    import pipeline_pkg::*;
#(
    parameter int unsigned ADDR_W      = 17,
    parameter int unsigned WAIT_CYCLES = 4
) (
    input  logic              clock,
    input  logic              reset,
    // Fetch port
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic              if_ready,
    output logic [31:0]       if_rdata,
    // Data port
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [31:0]       mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic              mem_ready,
    output logic [31:0]       mem_rdata,
    // Pipeline stalls
    output logic              if_stall,
    output logic              mem_stall,
    // SRAM side
    output logic              sram_en,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [31:0]       sram_wdata,
    input  logic [31:0]       sram_rdata
);

    localparam int unsigned      CNT_W    = cnt_width(WAIT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

    state_e state_q, state_d;

    logic              port_q;
    logic              last_grant_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       if_rdata_q;
    logic [31:0]       mem_rdata_q;

    logic        grant;
    logic        grant_port;
    logic [31:0] sel_addr;
    logic        sel_we;
    logic [31:0] sel_wdata;
    logic        latch;
    logic        cnt_load;
    logic        cnt_dec;
    logic        cnt_zero;
    logic        capture;

    // Byte offset and bits above the SRAM range are ignored by design.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{sel_addr[31:ADDR_W+WORD_OFFSET], sel_addr[WORD_OFFSET-1:0]};

    // Arbitration: a lone request wins; on a tie the port not granted last wins.
    always_comb begin
        grant      = 1'b0;
        grant_port = PORT_IF;
        if (if_req && mem_req) begin
            grant      = 1'b1;
            grant_port = (last_grant_q == PORT_IF) ? PORT_MEM : PORT_IF;
        end else if (mem_req) begin
            grant      = 1'b1;
            grant_port = PORT_MEM;
        end else if (if_req) begin
            grant      = 1'b1;
            grant_port = PORT_IF;
        end
    end

    // Request fields of the winning port; fetch never writes.
    always_comb begin
        sel_addr  = if_addr;
        sel_we    = 1'b0;
        sel_wdata = '0;
        if (grant_port == PORT_MEM) begin
            sel_addr  = mem_addr;
            sel_we    = mem_we;
            sel_wdata = mem_wdata;
        end
    end

    // Next-state logic and counter control.
    always_comb begin
        state_d  = state_q;
        latch    = 1'b0;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (grant) begin
                    latch    = 1'b1;
                    cnt_load = 1'b1;
                    state_d  = StAccess;
                end
            end
            StAccess: begin
                cnt_dec = 1'b1;
                if (cnt_zero) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Request latches: frozen for the whole access so requester changes are ignored.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            port_q  <= PORT_IF;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (latch) begin
            port_q  <= grant_port;
            we_q    <= sel_we;
            addr_q  <= sel_addr[ADDR_W+WORD_OFFSET-1:WORD_OFFSET];
            wdata_q <= sel_wdata;
        end
    end

    // Round-robin history, updated when an access completes.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_grant_q <= PORT_IF;
        end else if (state_q == StDone) begin
            last_grant_q <= port_q;
        end
    end

    assign capture = (state_q == StAccess) && cnt_zero && !we_q;

    // Read data capture in the last ACCESS cycle; writes leave both registers alone.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
        end else if (capture) begin
            if (port_q == PORT_IF) begin
                if_rdata_q <= sram_rdata;
            end else begin
                mem_rdata_q <= sram_rdata;
            end
        end
    end

    sram_wait_counter #(
        .WIDTH (CNT_W)
    ) u_wait_counter (
        .clock      (clock),
        .reset      (reset),
        .load       (cnt_load),
        .load_value (CNT_LOAD),
        .dec        (cnt_dec),
        .zero       (cnt_zero)
    );

    // Strobes decode straight from the state so reset removes them without a clock.
    assign sram_en    = (state_q == StAccess);
    assign sram_we    = sram_en && we_q;
    assign sram_addr  = addr_q;
    assign sram_wdata = wdata_q;

    assign if_ready  = (state_q == StDone) && (port_q == PORT_IF);
    assign mem_ready = (state_q == StDone) && (port_q == PORT_MEM);
    assign if_rdata  = if_rdata_q;
    assign mem_rdata = mem_rdata_q;

    assign if_stall  = if_req && !if_ready;
    assign mem_stall = mem_req && !mem_ready;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter: WAIT_CYCLES=4 main instance plus a WAIT_CYCLES=1 build.
module tb_sram_port_arbiter;

    localparam int unsigned ADDR_W = 17;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    // WAIT_CYCLES=4 instance
    logic              if_req, if_ready, mem_req, mem_we, mem_ready;
    logic              if_stall, mem_stall, sram_en, sram_we;
    logic [31:0]       if_addr, if_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [31:0]       sram_wdata, sram_rdata;
    logic [ADDR_W-1:0] sram_addr;

    // WAIT_CYCLES=1 instance
    logic              w1_if_req, w1_if_ready, w1_mem_req, w1_mem_we, w1_mem_ready;
    logic              w1_if_stall, w1_mem_stall, w1_sram_en, w1_sram_we;
    logic [31:0]       w1_if_addr, w1_if_rdata, w1_mem_addr, w1_mem_wdata, w1_mem_rdata;
    logic [31:0]       w1_sram_wdata, w1_sram_rdata;
    logic [ADDR_W-1:0] w1_sram_addr;

    int errors = 0;
    int checks = 0;

    // Write monitor on the main instance's SRAM bus.
    int                wr_count = 0;
    logic [ADDR_W-1:0] wr_addr_seen;
    logic [31:0]       wr_data_seen;

    always @(posedge clock) begin
        if (sram_en && sram_we) begin
            wr_count     <= wr_count + 1;
            wr_addr_seen <= sram_addr;
            wr_data_seen <= sram_wdata;
        end
    end

    // Fixed SRAM contents seen by reads.
    function automatic logic [31:0] rom_word(input logic [ADDR_W-1:0] a);
        case (a)
            17'd4:   return 32'hDEAD_BEEF;
            17'd12:  return 32'hCAFE_F00D;
            17'd16:  return 32'h0BAD_C0DE;
            default: return 32'h0;
        endcase
    endfunction

    assign sram_rdata    = rom_word(sram_addr);
    assign w1_sram_rdata = rom_word(w1_sram_addr);

    sram_port_arbiter #(
        .ADDR_W      (ADDR_W),
        .WAIT_CYCLES (4)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_ready   (if_ready),
        .if_rdata   (if_rdata),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata),
        .if_stall   (if_stall),
        .mem_stall  (mem_stall),
        .sram_en    (sram_en),
        .sram_we    (sram_we),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata)
    );

    sram_port_arbiter #(
        .ADDR_W      (ADDR_W),
        .WAIT_CYCLES (1)
    ) dut_w1 (
        .clock      (clock),
        .reset      (reset),
        .if_req     (w1_if_req),
        .if_addr    (w1_if_addr),
        .if_ready   (w1_if_ready),
        .if_rdata   (w1_if_rdata),
        .mem_req    (w1_mem_req),
        .mem_we     (w1_mem_we),
        .mem_addr   (w1_mem_addr),
        .mem_wdata  (w1_mem_wdata),
        .mem_ready  (w1_mem_ready),
        .mem_rdata  (w1_mem_rdata),
        .if_stall   (w1_if_stall),
        .mem_stall  (w1_mem_stall),
        .sram_en    (w1_sram_en),
        .sram_we    (w1_sram_we),
        .sram_addr  (w1_sram_addr),
        .sram_wdata (w1_sram_wdata),
        .sram_rdata (w1_sram_rdata)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [5:0] vec;
        reset = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        vec = {sram_en, sram_we, if_ready, mem_ready, if_stall, mem_stall};
        checks++;
        if (vec !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 000000", vec);
        end
        checks++;
        if ({sram_addr, sram_wdata, if_rdata, mem_rdata} !== '0) begin
            errors++;
            $display("FAIL reset_data: got addr=%h wdata=%h if_rdata=%h mem_rdata=%h expected all 0",
                     sram_addr, sram_wdata, if_rdata, mem_rdata);
        end
        vec = {w1_sram_en, w1_sram_we, w1_if_ready, w1_mem_ready, w1_if_stall, w1_mem_stall};
        checks++;
        if (vec !== 6'b0 || {w1_sram_addr, w1_sram_wdata, w1_if_rdata, w1_mem_rdata} !== '0) begin
            errors++;
            $display("FAIL reset_w1: got ctrl=%b addr=%h wdata=%h expected zeros",
                     vec, w1_sram_addr, w1_sram_wdata);
        end
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_lone_fetch();
        logic [4:0] exp_vec;
        int stall_cycles = 0;
        if_addr = 32'h0000_0010;
        if_req  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            if (if_stall) stall_cycles++;
            exp_vec = {(i >= 1 && i <= 4), 1'b0, (i == 5), (i <= 4), 1'b0};
            checks++;
            if ({sram_en, sram_we, if_ready, if_stall, mem_ready} !== exp_vec) begin
                errors++;
                $display("FAIL fetch_ctrl[%0d]: got %b expected %b", i,
                         {sram_en, sram_we, if_ready, if_stall, mem_ready}, exp_vec);
            end
            if (i >= 1 && i <= 4) begin
                checks++;
                if (sram_addr !== 17'd4) begin
                    errors++;
                    $display("FAIL fetch_addr[%0d]: got %0d expected 4", i, sram_addr);
                end
            end
            if (i == 5) begin
                checks++;
                if (if_rdata !== 32'hDEAD_BEEF) begin
                    errors++;
                    $display("FAIL fetch_rdata: got %h expected deadbeef", if_rdata);
                end
            end
            tick();
        end
        if_req = 1'b0;
        checks++;
        if (stall_cycles != 5) begin
            errors++;
            $display("FAIL fetch_stall_len: got %0d expected 5", stall_cycles);
        end
        @(negedge clock);
        checks++;
        if ({sram_en, if_ready, if_stall} !== 3'b000) begin
            errors++;
            $display("FAIL fetch_after: got %b expected 000", {sram_en, if_ready, if_stall});
        end
        tick();
    endtask

    task automatic test_write();
        int wr_before;
        logic [3:0] exp_vec;
        // Prior read so mem_rdata holds a known non-zero value.
        mem_we   = 1'b0;
        mem_addr = 32'h0000_0030;
        mem_req  = 1'b1;
        repeat (5) tick();
        @(negedge clock);
        checks++;
        if (mem_ready !== 1'b1 || mem_rdata !== 32'hCAFE_F00D) begin
            errors++;
            $display("FAIL pre_read: got ready=%b rdata=%h expected 1 cafef00d", mem_ready, mem_rdata);
        end
        tick();
        mem_req = 1'b0;
        tick();
        wr_before = wr_count;
        mem_we    = 1'b1;
        mem_addr  = 32'h0000_0020;
        mem_wdata = 32'h1234_5678;
        mem_req   = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            exp_vec = {(i >= 1 && i <= 4), (i >= 1 && i <= 4), (i == 5), (i <= 4)};
            checks++;
            if ({sram_en, sram_we, mem_ready, mem_stall} !== exp_vec) begin
                errors++;
                $display("FAIL write_ctrl[%0d]: got %b expected %b", i,
                         {sram_en, sram_we, mem_ready, mem_stall}, exp_vec);
            end
            if (i >= 1 && i <= 4) begin
                checks++;
                if (sram_addr !== 17'd8 || sram_wdata !== 32'h1234_5678) begin
                    errors++;
                    $display("FAIL write_bus[%0d]: got addr=%0d wdata=%h expected 8 12345678",
                             i, sram_addr, sram_wdata);
                end
            end
            if (i == 5) begin
                checks++;
                if (mem_rdata !== 32'hCAFE_F00D) begin
                    errors++;
                    $display("FAIL write_rdata_kept: got %h expected cafef00d", mem_rdata);
                end
            end
            tick();
            // Requester fields change mid-access; the latched access must be unaffected.
            if (i == 2) begin
                mem_wdata = 32'hFFFF_FFFF;
                mem_addr  = 32'h0000_0040;
                mem_we    = 1'b0;
            end
        end
        mem_req = 1'b0;
        mem_we  = 1'b0;
        checks++;
        if (wr_count - wr_before != 4 || wr_addr_seen !== 17'd8 || wr_data_seen !== 32'h1234_5678) begin
            errors++;
            $display("FAIL write_strobes: got n=%0d addr=%0d data=%h expected 4 8 12345678",
                     wr_count - wr_before, wr_addr_seen, wr_data_seen);
        end
        tick();
    endtask

    task automatic test_round_robin_back_to_back();
        logic [4:0]  exp_vec;
        logic        exp_en;
        logic [ADDR_W-1:0] exp_addr;
        apply_reset();
        if_addr  = 32'h0000_0010;
        mem_addr = 32'h0000_0030;
        mem_we   = 1'b0;
        if_req   = 1'b1;
        mem_req  = 1'b1;
        for (int i = 0; i < 19; i++) begin
            @(negedge clock);
            exp_en   = (i >= 1 && i <= 4) || (i >= 7 && i <= 10) || (i >= 13 && i <= 16);
            exp_addr = (i <= 4) ? 17'd12 : ((i <= 10) ? 17'd4 : 17'd16);
            exp_vec  = {exp_en, (i == 11), (i == 5 || i == 17), (i <= 10), !(i == 5 || i >= 17)};
            checks++;
            if ({sram_en, if_ready, mem_ready, if_stall, mem_stall} !== exp_vec) begin
                errors++;
                $display("FAIL rr_ctrl[%0d]: got %b expected %b", i,
                         {sram_en, if_ready, mem_ready, if_stall, mem_stall}, exp_vec);
            end
            if (exp_en) begin
                checks++;
                if (sram_addr !== exp_addr) begin
                    errors++;
                    $display("FAIL rr_addr[%0d]: got %0d expected %0d", i, sram_addr, exp_addr);
                end
            end
            if (i == 5 || i == 17) begin
                checks++;
                if (mem_rdata !== ((i == 5) ? 32'hCAFE_F00D : 32'h0BAD_C0DE)) begin
                    errors++;
                    $display("FAIL rr_mem_rdata[%0d]: got %h expected %h", i, mem_rdata,
                             (i == 5) ? 32'hCAFE_F00D : 32'h0BAD_C0DE);
                end
            end
            if (i == 11) begin
                checks++;
                if (if_rdata !== 32'hDEAD_BEEF) begin
                    errors++;
                    $display("FAIL rr_if_rdata: got %h expected deadbeef", if_rdata);
                end
            end
            tick();
            // mem_req stays high across its ready: a second data access with a new address.
            if (i == 5) mem_addr = 32'h0000_0040;
            if (i == 11) if_req = 1'b0;
            if (i == 17) mem_req = 1'b0;
        end
    endtask

    task automatic test_reset_mid_access();
        int stray_ready = 0;
        if_addr = 32'h0000_0010;
        if_req  = 1'b1;
        tick();
        @(negedge clock);
        checks++;
        if (sram_en !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_first_access: got en=%b expected 1", sram_en);
        end
        @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({sram_en, sram_we, if_ready, mem_ready} !== 4'b0 || sram_addr !== '0 || if_rdata !== '0) begin
            errors++;
            $display("FAIL rst_mid_async: got en=%b we=%b addr=%0d if_rdata=%h expected 0 0 0 0",
                     sram_en, sram_we, sram_addr, if_rdata);
        end
        if_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            if (if_ready || mem_ready || sram_en) stray_ready++;
        end
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            if (if_ready || mem_ready || sram_en) stray_ready++;
        end
        checks++;
        if (stray_ready != 0) begin
            errors++;
            $display("FAIL rst_mid_no_ready: got %0d active cycles expected 0", stray_ready);
        end
        tick();
        if_req = 1'b1;
        repeat (5) tick();
        @(negedge clock);
        checks++;
        if (if_ready !== 1'b1 || if_rdata !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL rst_mid_reissue: got ready=%b rdata=%h expected 1 deadbeef",
                     if_ready, if_rdata);
        end
        tick();
        if_req = 1'b0;
        tick();
    endtask

    task automatic test_wait_one();
        logic [2:0] exp_vec;
        w1_if_addr = 32'h0000_0010;
        w1_if_req  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            exp_vec = {(i == 1), (i == 2), (i <= 1)};
            checks++;
            if ({w1_sram_en, w1_if_ready, w1_if_stall} !== exp_vec) begin
                errors++;
                $display("FAIL w1_fetch[%0d]: got %b expected %b", i,
                         {w1_sram_en, w1_if_ready, w1_if_stall}, exp_vec);
            end
            if (i == 1) begin
                checks++;
                if (w1_sram_addr !== 17'd4) begin
                    errors++;
                    $display("FAIL w1_addr: got %0d expected 4", w1_sram_addr);
                end
            end
            if (i == 2) begin
                checks++;
                if (w1_if_rdata !== 32'hDEAD_BEEF) begin
                    errors++;
                    $display("FAIL w1_if_rdata: got %h expected deadbeef", w1_if_rdata);
                end
            end
            tick();
            if (i == 2) w1_if_req = 1'b0;
        end
        w1_mem_addr = 32'h0000_0030;
        w1_mem_req  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            checks++;
            if ({w1_sram_en, w1_mem_ready} !== {(i == 1), (i == 2)}) begin
                errors++;
                $display("FAIL w1_mem[%0d]: got %b expected %b", i,
                         {w1_sram_en, w1_mem_ready}, {(i == 1), (i == 2)});
            end
            if (i == 2) begin
                checks++;
                if (w1_mem_rdata !== 32'hCAFE_F00D) begin
                    errors++;
                    $display("FAIL w1_mem_rdata: got %h expected cafef00d", w1_mem_rdata);
                end
            end
            tick();
        end
        w1_mem_req = 1'b0;
        tick();
    endtask

    initial begin
        reset        = 1'b1;
        if_req       = 1'b0;
        if_addr      = '0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        w1_if_req    = 1'b0;
        w1_if_addr   = '0;
        w1_mem_req   = 1'b0;
        w1_mem_we    = 1'b0;
        w1_mem_addr  = '0;
        w1_mem_wdata = '0;

        test_reset();
        test_lone_fetch();
        test_write();
        test_round_robin_back_to_back();
        test_reset_mid_access();
        test_wait_one();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
